// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port bidirectional 16-bit memory between
// port 0 (CPU load/store) and port 1 (DMA/loader).
//
// Each transaction is IDLE (arbitrate and latch operands) -> ACCESS (memory
// enabled, bus driven for writes, read data captured at the closing edge)
// -> ACK (one-cycle ack to the winner) -> IDLE.
//
// Ports:
//   clk, reset (sync, active-low)
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1  requester inputs
//   rdata0/rdata1, ack0/ack1                        requester outputs
//   busy                                            high in ACCESS and ACK
//   mem_enable, mem_read_write (1=read), mem_address, mem_data (inout)
//
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins
// every tie, port 1 can starve). Default is round-robin.
module mem_arbiter #(
  parameter int unsigned address_size = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [address_size-1:0] addr0,
  input  logic [address_size-1:0] addr1,
  input  logic [15:0]             wdata0,
  input  logic [15:0]             wdata1,
  output logic [15:0]             rdata0,
  output logic [15:0]             rdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic                    busy,
  output logic                    mem_enable,
  output logic                    mem_read_write,
  output logic [address_size-1:0] mem_address,
  inout  wire  [15:0]             mem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic                    sel;        // port being served
  logic                    grant;      // arbitration result in IDLE
  logic                    lat_we;
  logic [address_size-1:0] lat_addr;
  logic [15:0]             lat_wdata;
  logic                    drive;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb grant = !req0;
`else
  logic last;                          // previously served port
  // Port 1 wins if alone, or on a tie when port 0 was served last.
  always_comb grant = req1 && (!req0 || !last);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    busy           = 1'b0;
    mem_enable     = 1'b0;
    mem_read_write = 1'b1;
    mem_address    = '0;
    ack0           = 1'b0;
    ack1           = 1'b0;
    drive          = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) state_nx = ACCESS;
      end
      ACCESS: begin
        busy           = 1'b1;
        mem_enable     = 1'b1;
        mem_read_write = !lat_we;
        mem_address    = lat_addr;
        drive          = lat_we;
        state_nx       = ACK;
      end
      ACK: begin
        busy     = 1'b1;
        ack0     = !sel;
        ack1     = sel;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_data = drive ? lat_wdata : 'z;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        sel       <= grant;
        lat_we    <= grant ? we1 : we0;
        lat_addr  <= grant ? addr1 : addr0;
        lat_wdata <= grant ? wdata1 : wdata0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last      <= grant;
`endif
      end
      if (state == ACCESS && !lat_we) begin
        if (sel) rdata1 <= mem_data;
        else     rdata0 <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a transaction-level reference model
// and a small memory attached to the shared bus.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [15:0] rdata0, rdata1, mem_address;
  logic        ack0, ack1, busy, mem_enable, mem_read_write;
  wire  [15:0] mem_data;

  always #5 clk = ~clk;

  mem_arbiter #(.address_size(16)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
    .busy(busy), .mem_enable(mem_enable), .mem_read_write(mem_read_write),
    .mem_address(mem_address), .mem_data(mem_data)
  );

  // Bench memory: asynchronous read onto the bus, write at the clock edge.
  logic [15:0] tmem [256];
  assign mem_data = (mem_enable && mem_read_write) ? tmem[mem_address[7:0]] : 16'bz;

  // Reference model: phase 0 idle, 1 memory access, 2 acknowledge.
  int          tphase = 0;
  logic        m_win = 1'b0, m_we = 1'b0, m_last = 1'b1;
  logic [15:0] m_addr = '0, m_wdata = '0;
  logic [15:0] refmem [256];
  logic [15:0] m_rd [2];
  int          glog[$];

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no ack within cycle budget, expected ack", name);
  endtask

  task automatic model_step();
    if (!rst_n) begin
      // The bench memory still sees the write strobe on the reset edge.
      if (tphase == 1 && m_we) refmem[m_addr[7:0]] = m_wdata;
      tphase = 0;
      m_last = 1'b1;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else begin
      case (tphase)
        0: if (req0 || req1) begin
          if (req0 && req1) m_win = FIXED ? 1'b0 : !m_last;
          else              m_win = !req0;
          m_we    = m_win ? we1 : we0;
          m_addr  = m_win ? addr1 : addr0;
          m_wdata = m_win ? wdata1 : wdata0;
          m_last  = m_win;
          glog.push_back(int'(m_win));
          tphase  = 1;
        end
        1: begin
          if (m_we) refmem[m_addr[7:0]] = m_wdata;
          else      m_rd[m_win] = refmem[m_addr[7:0]];
          tphase = 2;
        end
        default: tphase = 0;
      endcase
    end
  endtask

  task automatic compare();
    logic acc;
    acc = (tphase == 1);
    chk("busy", 32'(busy), 32'(tphase != 0));
    chk("mem_enable", 32'(mem_enable), 32'(acc));
    chk("mem_read_write", 32'(mem_read_write), acc ? 32'(!m_we) : 32'd1);
    chk("mem_address", 32'(mem_address), acc ? 32'(m_addr) : 32'd0);
    chk("ack0", 32'(ack0), 32'(tphase == 2 && !m_win));
    chk("ack1", 32'(ack1), 32'(tphase == 2 && m_win));
    chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
    chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
    if (acc && m_we) chk("mem_data_write", 32'(mem_data), 32'(m_wdata));
  endtask

  task automatic txn0(input logic w, input logic [15:0] a, input logic [15:0] d, output int lat);
    we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ack0) begin lat = i; break; end
    end
    if (lat == 0) timeout("ack0_wait");
    req0 = 1'b0;
  endtask

  task automatic txn1(input logic w, input logic [15:0] a, input logic [15:0] d, output int lat);
    we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ack1) begin lat = i; break; end
    end
    if (lat == 0) timeout("ack1_wait");
    req1 = 1'b0;
  endtask

  task automatic wait_access(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_enable) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: mem_enable never rose, expected access", name);
    end
  endtask

  initial begin
    int lat;
    int n0, n1;
    for (int i = 0; i < 256; i++) begin
      tmem[i]   = 16'h1000 + 16'(i);
      refmem[i] = 16'h1000 + 16'(i);
    end
    m_rd[0] = '0;
    m_rd[1] = '0;

    fork
      forever @(posedge clk) model_step();
      forever @(posedge clk) if (mem_enable && !mem_read_write) tmem[mem_address[7:0]] = mem_data;
      forever begin
        @(negedge clk);
        if (checking) compare();
      end
    join_none

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_mem_rw", 32'(mem_read_write), 32'd1);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    checking = 1'b1;
    rst_n = 1'b1;

    // Port 0 write then port 1 read of the same word.
    @(posedge clk); #1;
    txn0(1'b1, 16'h0010, 16'hBEEF, lat);
    chk("lat_write0", 32'(lat), 32'd3);
    @(posedge clk); #1;
    txn1(1'b0, 16'h0010, 16'h0000, lat);
    chk("lat_read1", 32'(lat), 32'd3);
    chk("rdata1_beef", 32'(rdata1), 32'hBEEF);

    // Simultaneous requests, re-asserted after each ack.
    repeat (2) @(posedge clk);
    glog.delete();
    n0 = FIXED ? 4 : 2;
    n1 = FIXED ? 1 : 2;
    #1;
    fork
      begin
        int l0;
        for (int k = 0; k < n0; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          txn0(1'b0, 16'h0040 + 16'(k), 16'h0000, l0);
        end
      end
      begin
        int l1;
        for (int k = 0; k < n1; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          txn1(1'b0, 16'h0050 + 16'(k), 16'h0000, l1);
        end
      end
    join
    chk("order_count", 32'(glog.size()), 32'(n0 + n1));
    if (glog.size() >= 4) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("order_%0d", k), 32'(glog[k]), FIXED ? 32'd0 : 32'(k % 2));
    end

    // Port 0 arrives while port 1 is in ACCESS.
    repeat (2) @(posedge clk);
    glog.delete();
    #1;
    fork
      begin
        int l1;
        txn1(1'b0, 16'h0003, 16'h0000, l1);
        chk("lat_read1_b", 32'(l1), 32'd3);
      end
      begin
        int l0;
        wait_access("late_req0");
        txn0(1'b0, 16'h0005, 16'h0000, l0);
        chk("lat_late0", 32'(l0), 32'd4);
      end
    join
    chk("rdata1_1003", 32'(rdata1), 32'h1003);
    chk("rdata0_1005", 32'(rdata0), 32'h1005);
    chk("late_order_n", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("late_order_0", 32'(glog[0]), 32'd1);
      chk("late_order_1", 32'(glog[1]), 32'd0);
    end

    // Operand changes during ACCESS must not reach memory.
    repeat (2) @(posedge clk); #1;
    fork
      txn0(1'b1, 16'h0020, 16'h1234, lat);
      begin
        wait_access("operand_change");
        addr0  = 16'h0021;
        wdata0 = 16'hFFFF;
      end
    join
    @(negedge clk);
    chk("latched_write", 32'(tmem[8'h20]), 32'h1234);
    chk("untouched_word", 32'(tmem[8'h21]), 32'h1021);

    // Reset during a write ACCESS aborts without ack.
    repeat (2) @(posedge clk); #1;
    we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'hAAAA; req0 = 1'b1;
    wait_access("reset_abort");
    rst_n = 1'b0;
    req0  = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack0", 32'(ack0), 32'd0);
    chk("abort_enable", 32'(mem_enable), 32'd0);
    chk("abort_rdata0", 32'(rdata0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
